cut_ctl_agc: RTL and testbench
==============================

Name: cut_ctl_agc

Overview:
- Automatic gain controller that drives the 3-bit cut_ctl of the DDC bit-slice/saturation stage (cut_ctl_top_ddc).
- Measures the sign-bit headroom of 32-bit I/Q samples over a fixed window of downsampled samples.
- At each window end it picks the next gain level: fast attack (drop immediately), slow release (rise at most one step per window).
- cut_ctl changes only at window boundaries, so every window is sliced with a single gain.

Parameters:
- LEN, 32, I/Q sample width; must be >= 24.
- FRAME_LEN, 1024, accepted samples per measurement window; must be >= 2.
- CNT_W, 16, width of the sample and saturation counters; 2^CNT_W must exceed FRAME_LEN.
- BACKOFF, 1, safety levels subtracted from the measured headroom; range 0..7.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  run the AGC; 0 forces IDLE
- manual_en  in  1  override: cut_ctl follows manual_cut
- manual_cut  in  3  override cut value
- frame_start  in  1  one-cycle pulse that re-aligns the window, e.g. to PRT start
- sample_valid  in  1  qualifies data_i/data_q; same strobe as downsample_valid
- data_i  in  LEN  signed I sample
- data_q  in  LEN  signed Q sample
- cut_ctl  out  3  to the slice stage
- cut_update  out  1  one-cycle pulse when cut_ctl changes value
- sat_cnt  out  CNT_W  saturations counted in the last window at the gain then applied
- peak_level  out  3  minimum feasible level seen in the last window
- stats_valid  out  1  one-cycle pulse when sat_cnt and peak_level update

Behaviour:
- Gain level L (0..7) maps to cut_ctl: L=0 -> 7 (pass-through, x1); L>=1 -> L-1 (x2^L).
- Reset values: cut_ctl=7, L=0, cut_update=0, sat_cnt=0, peak_level=0, stats_valid=0, all counters 0, state IDLE.
- Per-sample feasibility, combinational:
  - s(x) = (number of consecutive bits from the MSB equal to the MSB) - 1, capped at 7.
  - f = min(s(I), s(Q)).
  - The sample saturates at the current level when f < L.
- Window registers: smp_cnt, sat_acc (saturating, no wrap), fmin (reset value 7).
- FSM:
  - IDLE: counters cleared; cut_ctl held. Go to MEASURE when enable=1.
  - MEASURE: on sample_valid, smp_cnt++, fmin=min(fmin,f), sat_acc += (f<L). The FRAME_LEN-th accepted sample moves the FSM to DECIDE on the next edge.
  - DECIDE (1 cycle):
    - tgt = fmin>BACKOFF ? fmin-BACKOFF : 0.
    - If tgt<L, newL=tgt.
    - Else if tgt>L and sat_acc==0, newL=L+1.
    - Else newL=L.
  - APPLY (1 cycle):
    - L<=newL; cut_ctl<=map(newL); sat_cnt<=sat_acc; peak_level<=fmin.
    - stats_valid=1. cut_update=1 only if cut_ctl changed.
    - Clear counters, fmin<=7, return to MEASURE.
- Latency: last sample accepted at edge t; new cut_ctl, cut_update and stats_valid are visible after edge t+2.
- sample_valid during DECIDE or APPLY is ignored for statistics. Upstream guarantees a sample spacing of at least 3 cycles.
- frame_start in MEASURE:
  - Clears the counters, sets fmin=7, no decision.
  - A coincident sample is counted as sample 1 of the new window.
  - frame_start wins over a coincident final sample.
- frame_start in DECIDE or APPLY is ignored.
- enable=0 in any state: go to IDLE next edge and discard the partial window. cut_ctl and L are held.
- manual_en=1:
  - cut_ctl<=manual_cut each cycle; cut_update pulses on each change.
  - L<=(manual_cut==7 ? 0 : manual_cut+1).
  - Measurement and stats continue; APPLY does not touch cut_ctl or L.
  - Auto adaptation resumes from that L when manual_en returns to 0.
- rst_n assertion mid-window: immediate asynchronous return to reset values.

Decomposition:
- Package cut_agc_pkg holds:
  - CUT_PASS=3'd7;
  - the FSM state encoding (IDLE, MEASURE, DECIDE, APPLY);
  - the level_to_cut and cut_to_level functions.
- Sub-module sign_headroom (LEN): combinational s(x) for one sample, instantiated twice (I and Q).

Test Plan:
- Apply reset with sample_valid toggling -> cut_ctl=7, all other outputs 0, no pulses.
- Run with FRAME_LEN=8, BACKOFF=1, I=Q=32'h0000_1000 constant -> cut_ctl steps 7,0,1,2,3,4,5 over six windows, then holds 5; peak_level=7; sat_cnt=0.
- At L=6, one window contains one I=32'h2000_0000 sample -> at window end sat_cnt=1, peak_level=1, L=0, cut_ctl=7, cut_update pulses exactly once.
- Feed Q=32'hFF00_0000 and I=32'h0000_1000 -> f=7, no saturation. Negative sign extension is handled.
- Pulse frame_start after sample 5 of 8 -> the decision occurs 8 samples after the pulse, and the stats exclude the first 5 samples.
- Set manual_en=1 with manual_cut=2, then release after 2 windows -> cut_ctl=2 immediately, and adaptation resumes from L=3. Also drop enable mid-window -> IDLE, cut_ctl held, no stats_valid.

Source files
------------

// File: rtl/cut_ctl_agc_pkg.sv
// Shared definitions for the cut_ctl automatic gain controller.
package cut_agc_pkg;

  // cut_ctl code for pass-through (gain x1)
  localparam logic [2:0] CUT_PASS = 3'd7;

  typedef enum logic [1:0] {
    IDLE,
    MEASURE,
    DECIDE,
    APPLY
  } agc_state_t;

  // Gain level 0 is pass-through; level L>=1 selects slice L-1 (gain 2^L).
  function automatic logic [2:0] level_to_cut(input logic [2:0] lvl);
    return (lvl == 3'd0) ? CUT_PASS : lvl - 3'd1;
  endfunction

  function automatic logic [2:0] cut_to_level(input logic [2:0] cut);
    return (cut == CUT_PASS) ? 3'd0 : cut + 3'd1;
  endfunction

endpackage

// File: rtl/cut_ctl_agc_sign_headroom.sv
// Redundant sign-bit count of one signed sample, capped at 7.
module sign_headroom #(
  parameter int unsigned LEN = 32
) (
  input  logic [LEN-1:0] x,
  output logic [2:0]     s
);

  logic [7:0] top;
  logic [7:0] eq;

  assign top = x[LEN-1 -: 8];
  // eq[k] set where bit k of the top byte matches the sign bit
  assign eq  = ~(top ^ {8{top[7]}});

  // Count the run of sign copies directly below the MSB
  always_comb begin
    casez (eq[6:0])
      7'b0??????: s = 3'd0;
      7'b10?????: s = 3'd1;
      7'b110????: s = 3'd2;
      7'b1110???: s = 3'd3;
      7'b11110??: s = 3'd4;
      7'b111110?: s = 3'd5;
      7'b1111110: s = 3'd6;
      default:    s = 3'd7;
    endcase
  end

endmodule

// File: rtl/cut_ctl_agc.sv
// Windowed AGC producing cut_ctl for the DDC slice stage: fast attack,
// slow release, gain changed only at window boundaries.
module cut_ctl_agc
  import cut_agc_pkg::*;
#(
  parameter int unsigned LEN       = 32,
  parameter int unsigned FRAME_LEN = 1024,
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned BACKOFF   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             manual_en,
  input  logic [2:0]       manual_cut,
  input  logic             frame_start,
  input  logic             sample_valid,
  input  logic [LEN-1:0]   data_i,
  input  logic [LEN-1:0]   data_q,
  output logic [2:0]       cut_ctl,
  output logic             cut_update,
  output logic [CNT_W-1:0] sat_cnt,
  output logic [2:0]       peak_level,
  output logic             stats_valid
);

  localparam logic [2:0]       BO         = 3'(BACKOFF);
  localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_LEN - 1);

  agc_state_t       state;
  logic [2:0]       lvl;
  logic [2:0]       new_lvl;
  logic [2:0]       fmin;
  logic [CNT_W-1:0] smp_cnt;
  logic [CNT_W-1:0] sat_acc;
  logic [CNT_W-1:0] sat_inc;
  logic [2:0]       s_i;
  logic [2:0]       s_q;
  logic [2:0]       f;
  logic [2:0]       tgt;
  logic             sat_now;

  sign_headroom #(.LEN(LEN)) u_hr_i (.x(data_i), .s(s_i));
  sign_headroom #(.LEN(LEN)) u_hr_q (.x(data_q), .s(s_q));

  // Per-sample feasible level, saturation test and backed-off target
  always_comb begin
    f       = (s_i < s_q) ? s_i : s_q;
    sat_now = (f < lvl);
    sat_inc = (sat_acc == '1) ? sat_acc : sat_acc + CNT_W'(1);
    tgt     = (fmin > BO) ? fmin - BO : '0;
  end

  // Window FSM, gain decision and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      lvl         <= '0;
      new_lvl     <= '0;
      fmin        <= 3'd7;
      smp_cnt     <= '0;
      sat_acc     <= '0;
      cut_ctl     <= CUT_PASS;
      cut_update  <= 1'b0;
      sat_cnt     <= '0;
      peak_level  <= '0;
      stats_valid <= 1'b0;
    end else begin
      cut_update  <= 1'b0;
      stats_valid <= 1'b0;
      if (!enable) begin
        state   <= IDLE;
        smp_cnt <= '0;
        sat_acc <= '0;
        fmin    <= 3'd7;
      end else begin
        unique case (state)
          IDLE: begin
            smp_cnt <= '0;
            sat_acc <= '0;
            fmin    <= 3'd7;
            state   <= MEASURE;
          end
          MEASURE: begin
            if (frame_start) begin
              // Realign: a coincident sample opens the new window
              smp_cnt <= sample_valid ? CNT_W'(1) : '0;
              sat_acc <= (sample_valid && sat_now) ? CNT_W'(1) : '0;
              fmin    <= sample_valid ? f : 3'd7;
            end else if (sample_valid) begin
              smp_cnt <= smp_cnt + CNT_W'(1);
              if (sat_now) sat_acc <= sat_inc;
              if (f < fmin) fmin <= f;
              if (smp_cnt == FRAME_LAST) state <= DECIDE;
            end
          end
          DECIDE: begin
            if (tgt < lvl)                          new_lvl <= tgt;
            else if (tgt > lvl && sat_acc == '0)    new_lvl <= lvl + 3'd1;
            else                                    new_lvl <= lvl;
            state <= APPLY;
          end
          APPLY: begin
            sat_cnt     <= sat_acc;
            peak_level  <= fmin;
            stats_valid <= 1'b1;
            smp_cnt     <= '0;
            sat_acc     <= '0;
            fmin        <= 3'd7;
            state       <= MEASURE;
            if (!manual_en) begin
              lvl        <= new_lvl;
              cut_ctl    <= level_to_cut(new_lvl);
              cut_update <= (level_to_cut(new_lvl) != cut_ctl);
            end
          end
          default: state <= IDLE;
        endcase
      end
      // Manual override sits last so it always owns cut_ctl and the level
      if (manual_en) begin
        cut_ctl    <= manual_cut;
        lvl        <= cut_to_level(manual_cut);
        cut_update <= (manual_cut != cut_ctl);
      end
    end
  end

endmodule

// File: tb/tb_cut_ctl_agc.sv
// Self-checking bench for cut_ctl_agc with a window-level reference model.
module tb_cut_ctl_agc;

  localparam int FL = 8;
  localparam int BK = 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        manual_en = 1'b0;
  logic [2:0]  manual_cut = 3'd0;
  logic        frame_start = 1'b0;
  logic        sample_valid = 1'b0;
  logic [31:0] data_i = '0;
  logic [31:0] data_q = '0;
  logic [2:0]  cut_ctl;
  logic        cut_update;
  logic [15:0] sat_cnt;
  logic [2:0]  peak_level;
  logic        stats_valid;

  cut_ctl_agc #(.LEN(32), .FRAME_LEN(FL), .CNT_W(16), .BACKOFF(BK)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .manual_en(manual_en),
    .manual_cut(manual_cut), .frame_start(frame_start),
    .sample_valid(sample_valid), .data_i(data_i), .data_q(data_q),
    .cut_ctl(cut_ctl), .cut_update(cut_update), .sat_cnt(sat_cnt),
    .peak_level(peak_level), .stats_valid(stats_valid)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int misc = 0;
  int nprint = 0;
  bit chk_on = 0;
  int upd_seen = 0;
  int stat_seen = 0;

  // Headroom straight from the definition: run of bits equal to the MSB, minus 1
  function automatic int sfn(logic [31:0] x);
    int n = 0;
    for (int i = 30; i >= 0; i--) begin
      if (x[i] != x[31]) break;
      n++;
    end
    return (n > 7) ? 7 : n;
  endfunction

  function automatic int lvl2cut(int l);
    return (l == 0) ? 7 : l - 1;
  endfunction

  // Reference model: whole windows are collected, then judged as a unit
  int m_cut, m_lvl, e_sat, e_peak, age, d_lvl, d_peak, d_sat;
  bit e_upd, e_stat, armed;
  int win_f[$];
  bit win_s[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cut = 7; m_lvl = 0; e_sat = 0; e_peak = 0; e_upd = 0; e_stat = 0;
      armed = 0; age = 0; win_f.delete(); win_s.delete();
    end else begin
      int fv;
      fv = (sfn(data_i) < sfn(data_q)) ? sfn(data_i) : sfn(data_q);
      e_upd = 0; e_stat = 0;
      if (!enable) begin
        armed = 0; age = 0; win_f.delete(); win_s.delete();
      end else if (!armed) begin
        armed = 1;
      end else if (age == 0) begin
        if (frame_start) begin
          win_f.delete(); win_s.delete();
        end
        if (sample_valid) begin
          win_f.push_back(fv); win_s.push_back(fv < m_lvl);
          if (!frame_start && win_f.size() == FL) age = 1;
        end
      end else if (age == 1) begin
        int tgt;
        d_peak = 7; d_sat = 0;
        foreach (win_f[k]) begin
          if (win_f[k] < d_peak) d_peak = win_f[k];
          if (win_s[k]) d_sat++;
        end
        tgt = (d_peak > BK) ? d_peak - BK : 0;
        if (tgt < m_lvl) d_lvl = tgt;
        else if (tgt > m_lvl && d_sat == 0) d_lvl = m_lvl + 1;
        else d_lvl = m_lvl;
        age = 2;
      end else begin
        e_sat = d_sat; e_peak = d_peak; e_stat = 1;
        if (!manual_en) begin
          if (lvl2cut(d_lvl) != m_cut) e_upd = 1;
          m_lvl = d_lvl; m_cut = lvl2cut(d_lvl);
        end
        age = 0; win_f.delete(); win_s.delete();
      end
      if (manual_en) begin
        if (int'(manual_cut) != m_cut) e_upd = 1;
        m_cut = manual_cut;
        m_lvl = (manual_cut == 3'd7) ? 0 : int'(manual_cut) + 1;
      end
    end
  end

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    if (cut_update) upd_seen++;
    if (stats_valid) stat_seen++;
    if (chk_on) begin
      vectors++;
      if (cut_ctl !== 3'(m_cut) || cut_update !== e_upd || stats_valid !== e_stat ||
          sat_cnt !== 16'(e_sat) || peak_level !== 3'(e_peak)) begin
        misc++;
        if (nprint < 20) begin
          nprint++;
          $display("FAIL cycle t=%0t: cut_ctl %0d want %0d, cut_update %0b want %0b, stats_valid %0b want %0b, sat_cnt %0d want %0d, peak_level %0d want %0d",
                   $time, cut_ctl, m_cut, cut_update, e_upd, stats_valid, e_stat,
                   sat_cnt, e_sat, peak_level, e_peak);
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      misc++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input bit sv, input bit fs, input logic [31:0] di, input logic [31:0] dq);
    sample_valid = sv; frame_start = fs; data_i = di; data_q = dq;
    @(posedge clk); #1;
    sample_valid = 1'b0; frame_start = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, data_i, data_q);
  endtask

  task automatic send(input int n, input logic [31:0] di, input logic [31:0] dq);
    repeat (n) begin
      step(1, 0, di, dq);
      idle(2);
    end
  endtask

  function automatic logic [31:0] rnd_smp();
    logic [31:0] v;
    v = $urandom >> $urandom_range(0, 31);
    if ($urandom_range(0, 1) == 1) v = ~v;
    return v;
  endfunction

  initial begin
    int u0, s0, gap, off;
    // Reset with sample_valid toggling
    for (int i = 0; i < 6; i++) step(i % 2 == 0, 0, 32'h7FFF_FFFF, 32'h0);
    chk("rst_cut_ctl", cut_ctl, 7);
    chk("rst_cut_update", cut_update, 0);
    chk("rst_stats_valid", stats_valid, 0);
    chk("rst_sat_cnt", sat_cnt, 0);
    chk("rst_peak_level", peak_level, 0);
    chk("s_small", sfn(32'h0000_1000), 7);
    chk("s_big", sfn(32'h2000_0000), 1);
    chk("s_neg", sfn(32'hFF00_0000), 7);
    chk_on = 1;
    rst_n = 1'b1;
    idle(2);
    enable = 1'b1;
    idle(2);

    // Slow release from pass-through up to the backed-off ceiling
    u0 = upd_seen;
    for (int w = 0; w < 7; w++) begin
      send(FL, 32'h0000_1000, 32'h0000_1000);
      idle(3);
    end
    chk("release_cut", cut_ctl, 5);
    chk("release_updates", upd_seen - u0, 6);
    chk("release_peak", peak_level, 7);
    chk("release_sat", sat_cnt, 0);

    // Fast attack on a single large sample
    u0 = upd_seen;
    send(FL - 1, 32'h0000_1000, 32'h0000_1000);
    send(1, 32'h2000_0000, 32'h0000_1000);
    idle(3);
    chk("attack_sat", sat_cnt, 1);
    chk("attack_peak", peak_level, 1);
    chk("attack_cut", cut_ctl, 7);
    chk("attack_updates", upd_seen - u0, 1);

    // Negative sample sign extension
    send(FL, 32'h0000_1000, 32'hFF00_0000);
    idle(3);
    chk("neg_peak", peak_level, 7);
    chk("neg_sat", sat_cnt, 0);

    // frame_start realigns the window after five samples
    s0 = stat_seen;
    send(5, 32'h2000_0000, 32'h0000_1000);
    step(0, 1, 32'h0, 32'h0);
    idle(2);
    send(FL - 1, 32'h0000_1000, 32'h0000_1000);
    chk("realign_no_early_stats", stat_seen - s0, 0);
    send(1, 32'h0000_1000, 32'h0000_1000);
    idle(3);
    chk("realign_stats", stat_seen - s0, 1);
    chk("realign_peak", peak_level, 7);
    chk("realign_cut", cut_ctl, 1);

    // Manual override then resumed adaptation
    manual_en = 1'b1; manual_cut = 3'd2;
    idle(1);
    chk("manual_cut", cut_ctl, 2);
    for (int w = 0; w < 2; w++) begin
      send(FL, 32'h0000_1000, 32'h0000_1000);
      idle(3);
    end
    chk("manual_held", cut_ctl, 2);
    manual_en = 1'b0;
    send(FL, 32'h0000_1000, 32'h0000_1000);
    idle(3);
    chk("resume_cut", cut_ctl, 3);

    // Disable mid-window discards the partial window
    s0 = stat_seen;
    send(4, 32'h2000_0000, 32'h2000_0000);
    enable = 1'b0;
    idle(20);
    chk("disable_cut_held", cut_ctl, 3);
    chk("disable_no_stats", stat_seen - s0, 0);
    enable = 1'b1;
    idle(2);

    // Randomized traffic
    gap = 3; off = 0;
    for (int c = 0; c < 4000; c++) begin
      bit sv, fs;
      sv = (gap >= 3) && ($urandom_range(0, 1) == 1);
      fs = ($urandom_range(0, 39) == 0);
      gap = sv ? 1 : gap + 1;
      if (off > 0) begin
        off--;
        if (off == 0) enable = 1'b1;
      end else if ($urandom_range(0, 299) == 0) begin
        enable = 1'b0; off = $urandom_range(1, 4);
      end
      if ($urandom_range(0, 199) == 0) begin
        manual_en = ~manual_en; manual_cut = 3'($urandom_range(0, 7));
      end
      if (c == 2000) begin
        #2 rst_n = 1'b0;
        #3 rst_n = 1'b1;
      end
      step(sv, fs, rnd_smp(), rnd_smp());
    end
    idle(4);
    chk_on = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, misc);
    $finish;
  end

endmodule
